// File: rtl/spi_i2c_bridge_pkg.sv
// -----------------------------------------------------------------------------
// spi_i2c_bridge_pkg
// Shared definitions for the SPI-to-I2C bridge command path:
//   - state_t     : command decoder FSM states
//   - RW_BIT      : bit of the command byte carrying the I2C direction
//   - ADDR_W      : width of the 7-bit I2C target address field
//   - I2C_WRITE / I2C_READ : encoding of the direction bit
// -----------------------------------------------------------------------------
package spi_i2c_bridge_pkg;

   typedef enum logic [2:0] {
      IDLE,
      GET_LEN,
      GET_DATA,
      ISSUE,
      XFER
   } state_t;

   localparam int RW_BIT = 7;
   localparam int ADDR_W = 7;

   localparam logic I2C_WRITE = 1'b0;
   localparam logic I2C_READ  = 1'b1;

endpackage

// File: rtl/spi_cmd_decoder_if.sv
// -----------------------------------------------------------------------------
// spi_cmd_decoder_if
// Bundles the SPI receive stream, the I2C request/data handshakes and the
// SPI transmit load path seen by spi_cmd_decoder.
//   modport master : the command decoder (drives requests, write data, tx load)
//   modport slave  : the surrounding SPI slave / I2C master side
// Parameters: WIDTH (byte width), LW (length field width).
// -----------------------------------------------------------------------------
interface spi_cmd_decoder_if
   import spi_i2c_bridge_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LW    = 5
);

   logic              rx_valid_i;
   logic [WIDTH-1:0]  rx_data_i;
   logic              cs_active_i;
   logic              i2c_req_valid_o;
   logic              i2c_req_ready_i;
   logic [ADDR_W-1:0] i2c_addr_o;
   logic              i2c_rw_o;
   logic [LW-1:0]     i2c_len_o;
   logic              i2c_wdata_valid_o;
   logic              i2c_wdata_ready_i;
   logic [WIDTH-1:0]  i2c_wdata_o;
   logic              i2c_rdata_valid_i;
   logic [WIDTH-1:0]  i2c_rdata_i;
   logic              i2c_done_i;
   logic              tx_load_o;
   logic [WIDTH-1:0]  tx_data_o;
   logic              frame_err_o;
   logic              busy_o;

   modport master (
      input  rx_valid_i, rx_data_i, cs_active_i,
      input  i2c_req_ready_i, i2c_wdata_ready_i,
      input  i2c_rdata_valid_i, i2c_rdata_i, i2c_done_i,
      output i2c_req_valid_o, i2c_addr_o, i2c_rw_o, i2c_len_o,
      output i2c_wdata_valid_o, i2c_wdata_o,
      output tx_load_o, tx_data_o, frame_err_o, busy_o
   );

   modport slave (
      output rx_valid_i, rx_data_i, cs_active_i,
      output i2c_req_ready_i, i2c_wdata_ready_i,
      output i2c_rdata_valid_i, i2c_rdata_i, i2c_done_i,
      input  i2c_req_valid_o, i2c_addr_o, i2c_rw_o, i2c_len_o,
      input  i2c_wdata_valid_o, i2c_wdata_o,
      input  tx_load_o, tx_data_o, frame_err_o, busy_o
   );

endinterface

// File: rtl/cmd_byte_fifo.sv
// -----------------------------------------------------------------------------
// cmd_byte_fifo
// Synchronous FIFO buffering write payload bytes between frame parsing and
// the I2C write phase.
// Ports:
//   clk_i, reset_i      : clock, synchronous active-high reset
//   flush_i             : empties the FIFO (wins over push/pop)
//   push_i, push_data_i : write a byte (ignored when full)
//   pop_i               : drop the head byte (ignored when empty)
//   pop_data_o          : current head byte
//   empty_o, full_o     : status flags
//   count_o             : number of stored bytes, 0..DEPTH
// Parameters: WIDTH, DEPTH (power of two, >= 2).
// -----------------------------------------------------------------------------
module cmd_byte_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         pop_data_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty_o    = (wr_ptr == rd_ptr);
   assign full_o     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count_o    = wr_ptr - rd_ptr;
   assign pop_data_o = mem[rd_ptr[AW-1:0]];
   assign do_push    = push_i && !full_o && !flush_i;
   assign do_pop     = pop_i && !empty_o && !flush_i;

   // Storage array: no reset so it can map onto plain RAM/registers.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= push_data_i;
      end
   end

   // Pointer update; flush simply realigns both pointers at zero.
   always_ff @(posedge clk_i) begin
      if (reset_i || flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_cmd_decoder.sv
// -----------------------------------------------------------------------------
// spi_cmd_decoder
// Parses the SPI slave byte stream (command byte, length byte, write payload)
// into I2C transaction requests, streams buffered write payload to the I2C
// master and hands I2C read bytes back to the SPI slave transmit register.
// Ports:
//   clk_i   : single clock
//   reset_i : synchronous, active-high reset
//   bus     : spi_cmd_decoder_if.master (SPI rx stream, cs level, I2C request,
//             write data, read data, done, tx load, frame error, busy)
// Parameters: WIDTH, DEPTH, LW, TIMEOUT_CYCLES.
// Optional feature: define BRIDGE_FRAME_TIMEOUT_EN to abort frames that stall
// for TIMEOUT_CYCLES cycles in GET_LEN/GET_DATA; otherwise those states wait
// indefinitely and TIMEOUT_CYCLES is unused.
// -----------------------------------------------------------------------------
module spi_cmd_decoder
   import spi_i2c_bridge_pkg::*;
#(
   parameter int WIDTH          = 8,
   parameter int DEPTH          = 16,
   parameter int LW             = $clog2(DEPTH + 1),
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic               clk_i,
   input  logic               reset_i,
   spi_cmd_decoder_if.master  bus
);

   localparam logic [WIDTH-1:0] DEPTH_B = WIDTH'(DEPTH);

   state_t              state_q;
   state_t              state_d;
   logic [ADDR_W-1:0]   addr_q;
   logic                rw_q;
   logic [LW-1:0]       len_q;
   logic [LW-1:0]       rem_q;
   logic [WIDTH-1:0]    tx_data_q;
   logic                tx_load_q;
   logic                frame_err_q;

   logic                err_d;
   logic                abort;
   logic                cmd_latch;
   logic                len_latch;
   logic                rem_dec;
   logic                fifo_flush;
   logic                fifo_push;
   logic                fifo_pop;
   logic                fifo_empty;
   logic [WIDTH-1:0]    fifo_head;
   logic                wdata_valid;
   logic                rdata_capture;
   logic                timeout_hit;
   logic                unused_fifo_full;
   logic [$clog2(DEPTH):0] unused_fifo_count;

`ifdef BRIDGE_FRAME_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] timer_q;
   logic          in_frame;

   assign in_frame    = (state_q == GET_LEN) || (state_q == GET_DATA);
   assign timeout_hit = in_frame && !bus.rx_valid_i &&
                        (timer_q == TW'(TIMEOUT_CYCLES - 1));

   // Counts idle cycles inside a frame; any received byte restarts it.
   always_ff @(posedge clk_i) begin
      if (reset_i || !in_frame || bus.rx_valid_i) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_q + 1'b1;
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES > 0);
   assign timeout_hit    = 1'b0;
`endif

   cmd_byte_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .flush_i     (fifo_flush),
      .push_i      (fifo_push),
      .push_data_i (bus.rx_data_i),
      .pop_i       (fifo_pop),
      .pop_data_o  (fifo_head),
      .empty_o     (fifo_empty),
      .full_o      (unused_fifo_full),
      .count_o     (unused_fifo_count)
   );

   // State register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and control strobes. A cs drop (or timeout) during parsing
   // takes priority over a byte arriving in the same cycle, which is dropped.
   always_comb begin
      state_d    = state_q;
      err_d      = 1'b0;
      abort      = 1'b0;
      cmd_latch  = 1'b0;
      len_latch  = 1'b0;
      rem_dec    = 1'b0;
      fifo_flush = 1'b0;
      fifo_push  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.rx_valid_i && bus.cs_active_i) begin
               cmd_latch = 1'b1;
               state_d   = GET_LEN;
            end
         end
         GET_LEN: begin
            if (!bus.cs_active_i || timeout_hit) begin
               abort = 1'b1;
            end else if (bus.rx_valid_i) begin
               if ((bus.rx_data_i == '0) || (bus.rx_data_i > DEPTH_B)) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  len_latch = 1'b1;
                  state_d   = (rw_q == I2C_READ) ? ISSUE : GET_DATA;
               end
            end
         end
         GET_DATA: begin
            if (!bus.cs_active_i || timeout_hit) begin
               abort = 1'b1;
            end else if (bus.rx_valid_i) begin
               fifo_push = 1'b1;
               rem_dec   = 1'b1;
               if (rem_q == LW'(1)) begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            err_d = bus.rx_valid_i;
            if (bus.i2c_req_ready_i) begin
               state_d = XFER;
            end
         end
         XFER: begin
            err_d = bus.rx_valid_i;
            if (bus.i2c_done_i) begin
               fifo_flush = 1'b1;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (abort) begin
         fifo_flush = 1'b1;
         err_d      = 1'b1;
         state_d    = IDLE;
      end
   end

   assign wdata_valid   = (state_q == XFER) && (rw_q == I2C_WRITE) && !fifo_empty;
   assign fifo_pop      = wdata_valid && bus.i2c_wdata_ready_i;
   assign rdata_capture = (state_q == XFER) && (rw_q == I2C_READ) && bus.i2c_rdata_valid_i;

   // Frame fields, remaining-byte count, read-back byte and error pulse.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         addr_q      <= '0;
         rw_q        <= I2C_WRITE;
         len_q       <= '0;
         rem_q       <= '0;
         tx_data_q   <= '0;
         tx_load_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         frame_err_q <= err_d;
         tx_load_q   <= rdata_capture;
         if (cmd_latch) begin
            addr_q <= bus.rx_data_i[ADDR_W-1:0];
            rw_q   <= bus.rx_data_i[RW_BIT];
         end
         if (len_latch) begin
            len_q <= LW'(bus.rx_data_i);
            rem_q <= LW'(bus.rx_data_i);
         end else if (rem_dec) begin
            rem_q <= rem_q - LW'(1);
         end
         if (rdata_capture) begin
            tx_data_q <= bus.i2c_rdata_i;
         end
      end
   end

   assign bus.i2c_req_valid_o   = (state_q == ISSUE);
   assign bus.i2c_addr_o        = addr_q;
   assign bus.i2c_rw_o          = rw_q;
   assign bus.i2c_len_o         = len_q;
   assign bus.i2c_wdata_valid_o = wdata_valid;
   assign bus.i2c_wdata_o       = wdata_valid ? fifo_head : '0;
   assign bus.tx_load_o         = tx_load_q;
   assign bus.tx_data_o         = tx_data_q;
   assign bus.frame_err_o       = frame_err_q;
   assign bus.busy_o            = (state_q != IDLE);

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// -----------------------------------------------------------------------------
// tb_spi_cmd_decoder
// Directed frames drive the decoder; expected requests, write bytes, read-back
// bytes and frame errors are queued when issued and a negedge monitor pops
// and compares them whenever the DUT presents the matching output.
// Define BRIDGE_FRAME_TIMEOUT_EN to also exercise the inter-byte timeout.
// -----------------------------------------------------------------------------
module tb_spi_cmd_decoder;
   import spi_i2c_bridge_pkg::*;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;
   localparam int LW    = 5;
`ifdef BRIDGE_FRAME_TIMEOUT_EN
   localparam int TB_TIMEOUT = 8;
`else
   localparam int TB_TIMEOUT = 1024;
`endif

   logic clk;
   logic reset;

   int err_count;
   int check_count;

   // Expected request packed as {addr[6:0], rw, len[4:0]}.
   logic [12:0] exp_req[$];
   logic [7:0]  exp_wdata[$];
   logic [7:0]  exp_tx[$];
   logic        exp_err[$];

   spi_cmd_decoder_if #(.WIDTH(WIDTH), .LW(LW)) bus ();

   spi_cmd_decoder #(
      .WIDTH          (WIDTH),
      .DEPTH          (DEPTH),
      .LW             (LW),
      .TIMEOUT_CYCLES (TB_TIMEOUT)
   ) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         err_count++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
      end
   endtask

   // Advance one clock; inputs change and direct checks sample 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one received SPI byte for exactly one cycle.
   task automatic apply_stimulus(input logic [7:0] b);
      bus.rx_valid_i = 1'b1;
      bus.rx_data_i  = b;
      step();
      bus.rx_valid_i = 1'b0;
   endtask

   task automatic pulse_done();
      bus.i2c_done_i = 1'b1;
      step();
      bus.i2c_done_i = 1'b0;
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.i2c_req_valid_o) begin
            if (exp_req.size() == 0) begin
               check_output("req_unexpected", 32'd1, 32'd0);
            end else if (bus.i2c_req_ready_i) begin
               check_output("req", {bus.i2c_addr_o, bus.i2c_rw_o, bus.i2c_len_o},
                            exp_req.pop_front());
            end else begin
               check_output("req_hold", {bus.i2c_addr_o, bus.i2c_rw_o, bus.i2c_len_o},
                            exp_req[0]);
            end
         end
         if (bus.i2c_wdata_valid_o && bus.i2c_wdata_ready_i) begin
            if (exp_wdata.size() == 0) begin
               check_output("wdata_unexpected", 32'd1, 32'd0);
            end else begin
               check_output("wdata", bus.i2c_wdata_o, exp_wdata.pop_front());
            end
         end
         if (bus.tx_load_o) begin
            if (exp_tx.size() == 0) begin
               check_output("tx_unexpected", 32'd1, 32'd0);
            end else begin
               check_output("tx_data", bus.tx_data_o, exp_tx.pop_front());
            end
         end
         if (bus.frame_err_o) begin
            if (exp_err.size() == 0) begin
               check_output("err_unexpected", 32'd1, 32'd0);
            end else begin
               check_output("frame_err", 32'd1, exp_err.pop_front());
            end
         end
      end
   end

   initial begin
      err_count             = 0;
      check_count           = 0;
      reset                 = 1'b1;
      bus.rx_valid_i        = 1'b0;
      bus.rx_data_i         = '0;
      bus.cs_active_i       = 1'b0;
      bus.i2c_req_ready_i   = 1'b1;
      bus.i2c_wdata_ready_i = 1'b1;
      bus.i2c_rdata_valid_i = 1'b0;
      bus.i2c_rdata_i       = '0;
      bus.i2c_done_i        = 1'b0;
      repeat (3) step();

      $display("[TB] reset state");
      check_output("rst_busy", bus.busy_o, 0);
      check_output("rst_req_valid", bus.i2c_req_valid_o, 0);
      check_output("rst_wdata_valid", bus.i2c_wdata_valid_o, 0);
      check_output("rst_tx_load", bus.tx_load_o, 0);
      check_output("rst_tx_data", bus.tx_data_o, 0);
      check_output("rst_frame_err", bus.frame_err_o, 0);
      check_output("rst_addr", bus.i2c_addr_o, 0);
      check_output("rst_len", bus.i2c_len_o, 0);
      reset = 1'b0;
      step();

      $display("[TB] write frame 50 03 AA BB CC");
      bus.cs_active_i = 1'b1;
      exp_req.push_back({7'h50, 1'b0, 5'd3});
      exp_wdata.push_back(8'hAA);
      exp_wdata.push_back(8'hBB);
      exp_wdata.push_back(8'hCC);
      apply_stimulus(8'h50);
      apply_stimulus(8'h03);
      apply_stimulus(8'hAA);
      apply_stimulus(8'hBB);
      apply_stimulus(8'hCC);
      check_output("wr_req_rise", bus.i2c_req_valid_o, 1);
      step();
      check_output("wr_wdata0", {bus.i2c_wdata_valid_o, bus.i2c_wdata_o}, 9'h1AA);
      step();
      check_output("wr_wdata1", {bus.i2c_wdata_valid_o, bus.i2c_wdata_o}, 9'h1BB);
      step();
      check_output("wr_wdata2", {bus.i2c_wdata_valid_o, bus.i2c_wdata_o}, 9'h1CC);
      step();
      check_output("wr_drained", bus.i2c_wdata_valid_o, 0);
      pulse_done();
      check_output("wr_idle", bus.busy_o, 0);

      $display("[TB] read frame D0 02");
      exp_req.push_back({7'h50, 1'b1, 5'd2});
      exp_tx.push_back(8'h11);
      exp_tx.push_back(8'h22);
      apply_stimulus(8'hD0);
      apply_stimulus(8'h02);
      check_output("rd_req_rise", bus.i2c_req_valid_o, 1);
      step();
      bus.i2c_rdata_valid_i = 1'b1;
      bus.i2c_rdata_i       = 8'h11;
      step();
      check_output("rd_load0", {bus.tx_load_o, bus.tx_data_o}, 9'h111);
      bus.i2c_rdata_i       = 8'h22;
      step();
      bus.i2c_rdata_valid_i = 1'b0;
      check_output("rd_load1", {bus.tx_load_o, bus.tx_data_o}, 9'h122);
      step();
      check_output("rd_hold", {bus.tx_load_o, bus.tx_data_o}, 9'h022);
      pulse_done();
      check_output("rd_idle", bus.busy_o, 0);

      $display("[TB] bad lengths 0 and DEPTH+1");
      exp_err.push_back(1'b1);
      apply_stimulus(8'h50);
      apply_stimulus(8'h00);
      check_output("len0_err", bus.frame_err_o, 1);
      check_output("len0_idle", bus.busy_o, 0);
      step();
      check_output("len0_err_pulse", bus.frame_err_o, 0);
      exp_err.push_back(1'b1);
      apply_stimulus(8'h50);
      apply_stimulus(8'(DEPTH + 1));
      check_output("len17_err", bus.frame_err_o, 1);
      check_output("len17_idle", bus.busy_o, 0);
      step();

      $display("[TB] cs drop mid-payload");
      exp_err.push_back(1'b1);
      apply_stimulus(8'h50);
      apply_stimulus(8'h03);
      apply_stimulus(8'h01);
      bus.cs_active_i = 1'b0;
      apply_stimulus(8'h02);
      check_output("abort_err", bus.frame_err_o, 1);
      check_output("abort_idle", bus.busy_o, 0);
      bus.cs_active_i = 1'b1;
      step();
      exp_req.push_back({7'h52, 1'b0, 5'd1});
      exp_wdata.push_back(8'h77);
      apply_stimulus(8'h52);
      apply_stimulus(8'h01);
      apply_stimulus(8'h77);
      step();
      check_output("post_abort_wdata", {bus.i2c_wdata_valid_o, bus.i2c_wdata_o}, 9'h177);
      step();
      pulse_done();

      $display("[TB] ready held low, stray byte during ISSUE");
      bus.i2c_req_ready_i = 1'b0;
      exp_req.push_back({7'h60, 1'b0, 5'd1});
      exp_wdata.push_back(8'h99);
      exp_err.push_back(1'b1);
      apply_stimulus(8'h60);
      apply_stimulus(8'h01);
      apply_stimulus(8'h99);
      for (int i = 0; i < 10; i++) begin
         bus.rx_valid_i = (i == 4);
         bus.rx_data_i  = 8'h55;
         step();
         check_output("stall_req_valid", bus.i2c_req_valid_o, 1);
      end
      bus.rx_valid_i      = 1'b0;
      bus.i2c_req_ready_i = 1'b1;
      step();
      step();
      pulse_done();

      $display("[TB] reset mid-frame");
      apply_stimulus(8'h50);
      apply_stimulus(8'h02);
      apply_stimulus(8'hAB);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_output("mid_rst_busy", bus.busy_o, 0);
      check_output("mid_rst_tx_data", bus.tx_data_o, 0);
      check_output("mid_rst_req", bus.i2c_req_valid_o, 0);
      check_output("mid_rst_err", bus.frame_err_o, 0);
      step();
      exp_req.push_back({7'h50, 1'b0, 5'd1});
      exp_wdata.push_back(8'h5A);
      apply_stimulus(8'h50);
      apply_stimulus(8'h01);
      apply_stimulus(8'h5A);
      step();
      check_output("post_rst_wdata", {bus.i2c_wdata_valid_o, bus.i2c_wdata_o}, 9'h15A);
      step();
      pulse_done();

`ifdef BRIDGE_FRAME_TIMEOUT_EN
      $display("[TB] inter-byte timeout");
      exp_req.push_back({7'h50, 1'b0, 5'd1});
      exp_wdata.push_back(8'h33);
      apply_stimulus(8'h50);
      repeat (7) step();
      check_output("to7_busy", bus.busy_o, 1);
      apply_stimulus(8'h01);
      apply_stimulus(8'h33);
      step();
      step();
      pulse_done();
      exp_err.push_back(1'b1);
      apply_stimulus(8'h50);
      repeat (8) step();
      check_output("to8_err", bus.frame_err_o, 1);
      check_output("to8_idle", bus.busy_o, 0);
      step();
`endif

      repeat (4) step();
      check_output("left_req", exp_req.size(), 0);
      check_output("left_wdata", exp_wdata.size(), 0);
      check_output("left_tx", exp_tx.size(), 0);
      check_output("left_err", exp_err.size(), 0);
      check_output("end_idle", bus.busy_o, 0);

      $display("Result: errors=%0d of %0d checks", err_count, check_count);
      $finish;
   end

endmodule
